rr_sel_arbiter: RTL

//   Round-robin arbiter that chooses which of 4 request lines owns the shared
//   4:1 data mux. It sits directly upstream of mux_4x1 and drives that mux's
//   2-bit select. Each grant holds the select stable for a burst of up to
//   MAX_BURST accepted transfers, then rotates priority.

---
 rtl/rr_sel_arbiter.sv | 95 +++++++++
 1 files changed

// File: rtl/rr_sel_arbiter.sv
// Round-robin arbiter driving the 2-bit select of a 4:1 data mux.
// Each grant is held for up to MAX_BURST accepted transfers, then priority rotates.
module rr_sel_arbiter #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned SEL_W     = 2,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             out_ready,
  output logic [SEL_W-1:0] sel,
  output logic [N_REQ-1:0] gnt,
  output logic             out_valid,
  output logic             xfer
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  localparam logic [3:0] CntLast = 4'(MAX_BURST - 1);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [SEL_W-1:0] winner;

  assign out_valid = (state_q == StGrant) && req[sel_q];
  assign xfer      = out_valid && out_ready;
  assign sel       = sel_q;
  assign gnt       = gnt_q;

  // Scan from the farthest offset down so the closest set bit to ptr wins.
  always_comb begin
    winner = ptr_q;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      if (req[SEL_W'(32'(ptr_q) + off)]) begin
        winner = SEL_W'(32'(ptr_q) + off);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        gnt_d = '0;
        if (req != '0) begin
          state_d = StGrant;
          sel_d   = winner;
          gnt_d   = N_REQ'(1) << winner;
          cnt_d   = '0;
        end
      end
      StGrant: begin
        if (!req[sel_q] || (xfer && (cnt_q == CntLast))) begin
          // Release: sel stays put so the mux input does not glitch while idle.
          state_d = StIdle;
          gnt_d   = '0;
          cnt_d   = '0;
          ptr_d   = sel_q + SEL_W'(1);
        end else if (xfer) begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = StIdle;
        gnt_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sel_q   <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
